// File: rtl/cache_controller_pkg.sv
// Shared geometry and FSM encoding for the 2-way set-associative L1 data cache.
package cache_controller_pkg;

    localparam int unsigned TAG_W   = 10;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned SETS    = 64;
    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] sel_word(input logic [BLOCK_W-1:0] blk, input logic hi);
        return hi ? blk[BLOCK_W-1:WORD_W] : blk[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid/tag/data arrays with a combinational lookup and a single write port.
module cache_way
    import cache_controller_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   lk_idx_i,
    input  logic [TAG_W-1:0]   lk_tag_i,
    output logic               lk_hit_o,
    output logic [BLOCK_W-1:0] lk_data_o,
    input  logic               wr_en_i,
    input  logic               wr_valid_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [BLOCK_W-1:0] wr_data_i
);

    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [BLOCK_W-1:0] data_q [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    // Tag and data keep their contents across reset; only fills write them.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_i && wr_valid_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign lk_hit_o  = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
    assign lk_data_o = data_q[lk_idx_i];

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate L1 cache controller with zero-wait read hits and LRU fill.
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         address,
    input  logic [31:0]         wdata,
    input  logic                MEM_R_EN,
    input  logic                MEM_W_EN,
    output logic [31:0]         rdata,
    output logic                ready,
    output logic [31:0]         sram_address,
    output logic [31:0]         sram_wdata,
    output logic                sram_rd_en,
    output logic                sram_wr_en,
    input  logic [BLOCK_W-1:0]  sram_rdata,
    input  logic                sram_ready
);

    state_e             state_q, state_d;
    logic [SETS-1:0]    lru_q;
    logic               lru_we;
    logic               lru_bit;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               word_hi;
    logic [1:0]         way_hit;
    logic [1:0]         way_we;
    logic [1:0]         way_we_g;
    logic               way_wr_valid;
    logic [BLOCK_W-1:0] way_data [2];
    logic               hit;
    logic               hit_way;
    logic [BLOCK_W-1:0] hit_block;
    logic               fill_way;

    assign idx     = address[8:3];
    assign tag     = address[18:9];
    assign word_hi = address[2];

    // Way 0 takes priority should both ways ever report a hit.
    assign hit       = |way_hit;
    assign hit_way   = ~way_hit[0];
    assign hit_block = way_hit[0] ? way_data[0] : way_data[1];
    assign fill_way  = lru_q[idx];

    assign sram_address = MEM_W_EN ? address : {address[31:3], 1'b0, address[1:0]};
    assign sram_wdata   = wdata;

    cache_way u_way0 (
        .clk        (clk),
        .rst        (rst),
        .lk_idx_i   (idx),
        .lk_tag_i   (tag),
        .lk_hit_o   (way_hit[0]),
        .lk_data_o  (way_data[0]),
        .wr_en_i    (way_we_g[0]),
        .wr_valid_i (way_wr_valid),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (sram_rdata)
    );

    cache_way u_way1 (
        .clk        (clk),
        .rst        (rst),
        .lk_idx_i   (idx),
        .lk_tag_i   (tag),
        .lk_hit_o   (way_hit[1]),
        .lk_data_o  (way_data[1]),
        .wr_en_i    (way_we_g[1]),
        .wr_valid_i (way_wr_valid),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            if (lru_we) begin
                lru_q[idx] <= lru_bit;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ready        = 1'b0;
        rdata        = '0;
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        way_we       = '0;
        way_wr_valid = 1'b0;
        lru_we       = 1'b0;
        lru_bit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MEM_W_EN) begin
                    state_d = WR_THRU;
                    if (hit) begin
                        way_we[hit_way] = 1'b1;
                    end
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        ready   = 1'b1;
                        rdata   = sel_word(hit_block, word_hi);
                        lru_we  = 1'b1;
                        lru_bit = ~hit_way;
                    end else begin
                        state_d = RD_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            RD_MISS: begin
                sram_rd_en = 1'b1;
                if (sram_ready) begin
                    state_d          = IDLE;
                    ready            = 1'b1;
                    rdata            = sel_word(sram_rdata, word_hi);
                    way_we[fill_way] = 1'b1;
                    way_wr_valid     = 1'b1;
                    lru_we           = 1'b1;
                    lru_bit          = ~fill_way;
                end
            end
            WR_THRU: begin
                sram_wr_en = 1'b1;
                if (sram_ready) begin
                    state_d = IDLE;
                    ready   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        way_we_g = way_we & {2{~rst}};
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller with a hand-driven SRAM.
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int n_cmp = 0;
    int n_err = 0;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .wdata        (wdata),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts and ends 1 time unit after a rising edge; SRAM answers one cycle after rd_en rises.
    task automatic read_op(input logic [31:0] a, input bit exp_hit,
                           input logic [63:0] blk, input logic [31:0] exp_d);
        address  = a;
        MEM_R_EN = 1'b1;
        @(negedge clk);
        if (exp_hit) begin
            chk($sformatf("rd%0h_hit_ready", a), 64'(ready), 64'd1);
            chk($sformatf("rd%0h_hit_rdata", a), 64'(rdata), 64'(exp_d));
            chk($sformatf("rd%0h_hit_rd_en", a), 64'(sram_rd_en), 64'd0);
            @(posedge clk); #1;
            MEM_R_EN = 1'b0;
        end else begin
            chk($sformatf("rd%0h_detect_ready", a), 64'(ready), 64'd0);
            chk($sformatf("rd%0h_detect_rd_en", a), 64'(sram_rd_en), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("rd%0h_miss_rd_en", a), 64'(sram_rd_en), 64'd1);
            chk($sformatf("rd%0h_miss_ready", a), 64'(ready), 64'd0);
            chk($sformatf("rd%0h_miss_saddr", a), 64'(sram_address), 64'(a & 32'hFFFF_FFFB));
            @(posedge clk); #1;
            sram_ready = 1'b1;
            sram_rdata = blk;
            @(negedge clk);
            chk($sformatf("rd%0h_fill_ready", a), 64'(ready), 64'd1);
            chk($sformatf("rd%0h_fill_rdata", a), 64'(rdata), 64'(exp_d));
            @(posedge clk); #1;
            sram_ready = 1'b0;
            MEM_R_EN   = 1'b0;
            @(negedge clk);
            chk($sformatf("rd%0h_done_rd_en", a), 64'(sram_rd_en), 64'd0);
            chk($sformatf("rd%0h_done_ready", a), 64'(ready), 64'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic write_op(input logic [31:0] a, input logic [31:0] d, input bit also_rd);
        address  = a;
        wdata    = d;
        MEM_W_EN = 1'b1;
        MEM_R_EN = also_rd;
        @(negedge clk);
        chk($sformatf("wr%0h_accept_ready", a), 64'(ready), 64'd0);
        chk($sformatf("wr%0h_accept_rd_en", a), 64'(sram_rd_en), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("wr%0h_wr_en", a), 64'(sram_wr_en), 64'd1);
        chk($sformatf("wr%0h_rd_en", a), 64'(sram_rd_en), 64'd0);
        chk($sformatf("wr%0h_saddr", a), 64'(sram_address), 64'(a));
        chk($sformatf("wr%0h_swdata", a), 64'(sram_wdata), 64'(d));
        chk($sformatf("wr%0h_wait_ready", a), 64'(ready), 64'd0);
        @(posedge clk); #1;
        sram_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("wr%0h_done_ready", a), 64'(ready), 64'd1);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        MEM_W_EN   = 1'b0;
        MEM_R_EN   = 1'b0;
        @(negedge clk);
        chk($sformatf("wr%0h_idle_wr_en", a), 64'(sram_wr_en), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b1;
        address    = '0;
        wdata      = '0;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        sram_rdata = '0;
        sram_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rd_en", 64'(sram_rd_en), 64'd0);
        chk("rst_wr_en", 64'(sram_wr_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 0x100, 0x300, 0x500, 0x700 share index 0x20 with tags 0, 1, 2, 3.
        read_op(32'h100, 1'b0, 64'h2222_2222_1111_1111, 32'h1111_1111); // way0, lru=1
        read_op(32'h104, 1'b1, 64'h0, 32'h2222_2222);                   // hit way0, lru=1
        read_op(32'h300, 1'b0, 64'h4444_4444_3333_3333, 32'h3333_3333); // way1, lru=0
        read_op(32'h500, 1'b0, 64'h6666_6666_5555_5555, 32'h5555_5555); // way0 evicts 0x100, lru=1
        read_op(32'h300, 1'b1, 64'h0, 32'h3333_3333);                   // hit way1, lru=0
        read_op(32'h104, 1'b0, 64'h2222_2222_1111_1111, 32'h2222_2222); // way0 evicts 0x500, lru=1

        // Store hit invalidates way0 and leaves lru=1, so the refill lands in way1 over 0x300.
        write_op(32'h100, 32'hDEAD_BEEF, 1'b0);
        read_op(32'h100, 1'b0, 64'h2222_2222_DEAD_BEEF, 32'hDEAD_BEEF); // way1, lru=0
        read_op(32'h300, 1'b0, 64'h4444_4444_3333_3333, 32'h3333_3333); // way0, lru=1
        read_op(32'h104, 1'b1, 64'h0, 32'h2222_2222);

        // Simultaneous read and write requests take the write-through path.
        write_op(32'h404, 32'h1234_5678, 1'b1);

        // Reset during a read miss aborts it; a late sram_ready must not fill.
        address  = 32'h700;
        MEM_R_EN = 1'b1;
        @(negedge clk);
        chk("abort_detect_ready", 64'(ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_rd_en", 64'(sram_rd_en), 64'd1);
        @(posedge clk); #1;
        rst        = 1'b0;
        MEM_R_EN   = 1'b0;
        sram_ready = 1'b1;
        sram_rdata = 64'h8888_8888_7777_7777;
        @(negedge clk);
        chk("abort_after_rd_en", 64'(sram_rd_en), 64'd0);
        chk("abort_late_ready", 64'(ready), 64'd1);
        chk("abort_late_rdata", 64'(rdata), 64'd0);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        read_op(32'h700, 1'b0, 64'h8888_8888_7777_7777, 32'h7777_7777);
        read_op(32'h300, 1'b0, 64'h4444_4444_3333_3333, 32'h3333_3333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
